pacman_move_ctrl: RTL and testbench
===================================

// Module: pacman_move_ctrl
// PURPOSE
//  Downstream consumer of the maze wall stage. It samples the per-pixel wall flag (wallFill) while the raster scans.
//  From those samples it derives blocked[3:0] flags at pacman's edges, once per frame.
//  Once per frame (vertical blank) it commits the requested direction and steps pacman's position.
//  pacX/pacY feed the sprite renderer and the pellet/ghost logic.
// PARAMETERS
//  SPRITE    default 12    pacman square size in pixels (pacX,pacY = top-left)
//  STEP      default 2     pixels moved per update; also probe strip depth beyond each edge
//  MOVE_DIV  default 2     an update moves only every MOVE_DIV-th frame (1..15)
//  START_X   default 314   reset/start X (screen hCount units)
//  START_Y   default 254   reset/start Y (screen vCount units)
//  X_MIN     default 138   min legal pacX;  X_MAX default 490 max legal pacX
//  Y_MIN     default 32    min legal pacY;  Y_MAX default 408 max legal pacY
//  UPD_LINE  default 515   vCount of update point (first blank line)
// PORTS
//  clk       in   1   pixel-rate system clock
//  reset     in   1   synchronous, active-high reset
//  start     in   1   1-cycle pulse: leave IDLE, begin play
//  ack       in   1   1-cycle pulse: return to IDLE, position restored to START
//  hCount    in   10  raster column from VGA timing
//  vCount    in   10  raster line from VGA timing
//  bright    in   1   visible-area qualifier
//  wallFill  in   1   wall stage output for current (hCount,vCount), combinational
//  btnU/btnD/btnL/btnR  in  1 each  debounced direction requests, level
//  pacX      out  10  pacman left column
//  pacY      out  10  pacman top line
//  dir       out  2   current heading: 0=R 1=L 2=U 3=D
//  moving    out  1   1 when last update actually changed position
// BEHAVIOUR
//  Reset: state=IDLE, pacX=START_X, pacY=START_Y, dir=1(L), moving=0, reqDir=1, blocked=0, divCnt=0, primed=0.
//  FSM IDLE -> (start) SCAN -> (hCount==0 && vCount==UPD_LINE) UPDATE -> (next cycle) SCAN.
//  ack in any state -> IDLE next cycle, outputs restored to reset values.
//  ack and start in same cycle: ack wins.
//  FRAME start (hCount==0 && vCount==0): blocked<=0; primed<=1. Only seen in SCAN.
//  SCAN: when bright && wallFill, set blocked[d] if pixel lies in probe strip d:
//   R: x in [pacX+SPRITE, pacX+SPRITE+STEP-1], y in [pacY, pacY+SPRITE-1]
//   L: x in [pacX-STEP, pacX-1], same y span
//   U/D: y strip symmetric (above pacY / below pacY+SPRITE-1), x in [pacX, pacX+SPRITE-1]
//   Compares use 11-bit signed-safe arithmetic; no underflow when pacX<STEP.
//  reqDir: updated every cycle any button is high.
//   Priority U>D>L>R; holds last value when no button is pressed.
//  UPDATE (single cycle), only if primed:
//   divCnt<=divCnt+1, wrapping to 0 at MOVE_DIV-1. Move only when divCnt==MOVE_DIV-1.
//   On a move cycle: if !blocked[reqDir], dir<=reqDir (turn applied before step, same cycle).
//   Then if !blocked[new dir], step STEP along it. Clamp to [X_MIN,X_MAX]/[Y_MIN,Y_MAX].
//   moving<=1 iff position changed. On non-move cycles, moving is held.
//  primed==0 (reset/start mid-frame): UPDATE does nothing, so partial-frame probes are never used.
//  Button change during UPDATE cycle: value registered that cycle is used.
//  Outputs are registered; position changes are visible 1 cycle after the UPDATE cycle (in blanking, no tearing).
// CONFIGURATION
//  PAC_TUNNEL_EN defined:
//   moving L from pacX<X_MIN+STEP wraps pacX to X_MAX. Moving R past X_MAX wraps to X_MIN.
//   Vertical axis still clamps.
//  PAC_TUNNEL_EN undefined: both axes clamp, and moving=0 when clamped with no change.
// TESTING
//  1 Reset, no start, run 3 frames -> pacX=314, pacY=254, dir=1, moving=0.
//  2 start, no walls, no buttons, MOVE_DIV=1 -> pacX decrements by 2 per frame, dir=1, moving=1.
//  3 Wall model asserts wallFill at x=pacX-1 over pac rows; request L -> after update pacX unchanged, moving=0.
//  4 Heading L, press U while U strip is walled -> dir stays 1, pacX-=2.
//    Remove the U wall next frame -> dir=2, pacY-=2.
//  5 start at vCount=300 mid-frame -> first UPD_LINE makes no change. Second frame moves normally.
//  6 PAC_TUNNEL_EN: pacX=139, heading L -> pacX=490 after update.
//    Without the macro -> pacX=138, then stays at 138 with moving=0.

Source files
------------

// File: rtl/pacman_move_ctrl.sv
// Pacman movement controller: probes wall pixels around pacman during the raster scan and
// steps position/heading once per frame at the update line. Optional macro: PAC_TUNNEL_EN (horizontal wrap).
module pacman_move_ctrl #(
    parameter int SPRITE   = 12,
    parameter int STEP     = 2,
    parameter int MOVE_DIV = 2,
    parameter int START_X  = 314,
    parameter int START_Y  = 254,
    parameter int X_MIN    = 138,
    parameter int X_MAX    = 490,
    parameter int Y_MIN    = 32,
    parameter int Y_MAX    = 408,
    parameter int UPD_LINE = 515
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ack,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       bright,
    input  logic       wallFill,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    output logic [9:0] pacX,
    output logic [9:0] pacY,
    output logic [1:0] dir,
    output logic       moving
);

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

    localparam logic [1:0] DIR_R = 2'd0;
    localparam logic [1:0] DIR_L = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

`ifdef PAC_TUNNEL_EN
    localparam bit TUNNEL = 1'b1;
`else
    localparam bit TUNNEL = 1'b0;
`endif

    localparam logic signed [11:0] SZ  = 12'(SPRITE);
    localparam logic signed [11:0] ST  = 12'(STEP);
    localparam logic signed [11:0] ONE = 12'sd1;
    localparam logic [10:0] STP = 11'(STEP);
    localparam logic [10:0] XMN = 11'(X_MIN);
    localparam logic [10:0] XMX = 11'(X_MAX);
    localparam logic [10:0] YMN = 11'(Y_MIN);
    localparam logic [10:0] YMX = 11'(Y_MAX);
    localparam logic [9:0]  STP10  = 10'(STEP);
    localparam logic [9:0]  XMN10  = 10'(X_MIN);
    localparam logic [9:0]  XMX10  = 10'(X_MAX);
    localparam logic [9:0]  YMN10  = 10'(Y_MIN);
    localparam logic [9:0]  YMX10  = 10'(Y_MAX);
    localparam logic [9:0]  STX10  = 10'(START_X);
    localparam logic [9:0]  STY10  = 10'(START_Y);
    localparam logic [9:0]  UPD10  = 10'(UPD_LINE);
    localparam logic [3:0]  DIVMAX = 4'(MOVE_DIV - 1);

    state_t      state, stateNext;
    logic [1:0]  reqDir, reqNext, newDir;
    logic [3:0]  blocked, probeHit;
    logic [3:0]  divCnt;
    logic        primed;
    logic        frameStart, updPoint, anyBtn;
    logic [9:0]  nextX, nextY;
    logic        inXSpan, inYSpan;
    logic signed [11:0] hs, vs, px, py;
    logic [10:0] x11, y11;

    assign frameStart = (hCount == 10'd0) && (vCount == 10'd0);
    assign updPoint   = (hCount == 10'd0) && (vCount == UPD10);
    assign anyBtn     = btnU | btnD | btnL | btnR;

    // Probe geometry is done in signed 12-bit so strips left of / above column 0 never wrap.
    assign hs  = $signed({2'b00, hCount});
    assign vs  = $signed({2'b00, vCount});
    assign px  = $signed({2'b00, pacX});
    assign py  = $signed({2'b00, pacY});
    assign x11 = {1'b0, pacX};
    assign y11 = {1'b0, pacY};

    assign inXSpan = (hs >= px) && (hs <= px + SZ - ONE);
    assign inYSpan = (vs >= py) && (vs <= py + SZ - ONE);

    always_comb begin
        probeHit        = 4'b0000;
        probeHit[DIR_R] = inYSpan && (hs >= px + SZ) && (hs <= px + SZ + ST - ONE);
        probeHit[DIR_L] = inYSpan && (hs >= px - ST) && (hs <= px - ONE);
        probeHit[DIR_U] = inXSpan && (vs >= py - ST) && (vs <= py - ONE);
        probeHit[DIR_D] = inXSpan && (vs >= py + SZ) && (vs <= py + SZ + ST - ONE);
    end

    always_comb begin
        reqNext = reqDir;
        if (btnU)      reqNext = DIR_U;
        else if (btnD) reqNext = DIR_D;
        else if (btnL) reqNext = DIR_L;
        else if (btnR) reqNext = DIR_R;
    end

    // Turn first (if the requested side is open), then step along the resulting heading.
    always_comb begin
        newDir = blocked[reqNext] ? dir : reqNext;
        nextX  = pacX;
        nextY  = pacY;
        if (!blocked[newDir]) begin
            case (newDir)
                DIR_R: begin
                    if (x11 + STP > XMX) nextX = TUNNEL ? XMN10 : XMX10;
                    else                 nextX = pacX + STP10;
                end
                DIR_L: begin
                    if (x11 < XMN + STP) nextX = TUNNEL ? XMX10 : XMN10;
                    else                 nextX = pacX - STP10;
                end
                DIR_U: begin
                    if (y11 < YMN + STP) nextY = YMN10;
                    else                 nextY = pacY - STP10;
                end
                default: begin
                    if (y11 + STP > YMX) nextY = YMX10;
                    else                 nextY = pacY + STP10;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (ack) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) stateNext = SCAN;
                SCAN:    if (updPoint) stateNext = UPDATE;
                UPDATE:  stateNext = SCAN;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Datapath: ack restores everything exactly as reset does.
    always_ff @(posedge clk) begin
        if (reset || ack) begin
            pacX    <= STX10;
            pacY    <= STY10;
            dir     <= DIR_L;
            moving  <= 1'b0;
            reqDir  <= DIR_L;
            blocked <= 4'b0000;
            divCnt  <= 4'd0;
            primed  <= 1'b0;
        end else begin
            if (anyBtn) reqDir <= reqNext;
            case (state)
                IDLE: begin
                    if (start) begin
                        blocked <= 4'b0000;
                        primed  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (frameStart) begin
                        blocked <= 4'b0000;
                        primed  <= 1'b1;
                    end else if (bright && wallFill) begin
                        blocked <= blocked | probeHit;
                    end
                end
                UPDATE: begin
                    if (primed) begin
                        if (divCnt == DIVMAX) begin
                            divCnt <= 4'd0;
                            dir    <= newDir;
                            pacX   <= nextX;
                            pacY   <= nextY;
                            moving <= (nextX != pacX) || (nextY != pacY);
                        end else begin
                            divCnt <= divCnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Self-checking bench for pacman_move_ctrl: hand-computed frame table, corner sequences,
// then randomized frames checked against a frame-level reference model.
module tb_pacman_move_ctrl;

    localparam int SPRITE   = 12;
    localparam int STEP     = 2;
    localparam int MOVE_DIV = 2;
    localparam int START_X  = 314;
    localparam int START_Y  = 254;
    localparam int X_MIN    = 138;
    localparam int X_MAX    = 490;
    localparam int Y_MIN    = 32;
    localparam int Y_MAX    = 408;
    localparam int UPD_LINE = 515;

    logic       clk = 1'b0;
    logic       reset, start, ack, bright, wallFill;
    logic       btnU, btnD, btnL, btnR;
    logic [9:0] hCount, vCount;
    logic [9:0] pacX, pacY;
    logic [1:0] dir;
    logic       moving;

    int errors = 0;
    int checks = 0;

    pacman_move_ctrl #(
        .SPRITE(SPRITE), .STEP(STEP), .MOVE_DIV(MOVE_DIV),
        .START_X(START_X), .START_Y(START_Y),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .UPD_LINE(UPD_LINE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ack(ack),
        .hCount(hCount), .vCount(vCount), .bright(bright), .wallFill(wallFill),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
        .pacX(pacX), .pacY(pacY), .dir(dir), .moving(moving)
    );

    always #5 clk = ~clk;

    // Wall pixels for the current frame; vis=0 means the pixel is presented with bright low.
    int wallX[$];
    int wallY[$];
    bit wallVis[$];

    // Reference model state
    int mX, mY, mDir, mReq, mDiv;
    bit mMov, mPrimed;

    typedef struct {
        logic [3:0] bScan;
        logic [3:0] bUpd;
        int wallCode;
        int ex;
        int ey;
        int ed;
        int em;
    } vec_t;

    vec_t tbl[18];

    // Buttons are packed {U,D,L,R}
    task automatic applyStimulus(input int h, input int v, input logic br, input logic wf,
                                 input logic [3:0] btns);
        hCount   = 10'(h);
        vCount   = 10'(v);
        bright   = br;
        wallFill = wf;
        {btnU, btnD, btnL, btnR} = btns;
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int ex, input int ey, input int ed, input int em);
        checkValue({name, ".pacX"}, int'(pacX), ex);
        checkValue({name, ".pacY"}, int'(pacY), ey);
        checkValue({name, ".dir"}, int'(dir), ed);
        checkValue({name, ".moving"}, int'(moving), em);
    endtask

    // One condensed frame: frame-start pixel, optional scan of the box around (baseX,baseY),
    // the update-line pixel, then the update cycle itself with bUpd on the buttons.
    task automatic runFrame(input logic [3:0] bScan, input logic [3:0] bUpd,
                            input bit doScan, input int baseX, input int baseY);
        applyStimulus(0, 0, 1'b1, 1'b0, bScan);
        if (doScan) begin
            for (int y = baseY - STEP; y <= baseY + SPRITE + STEP - 1; y++) begin
                for (int x = baseX - STEP; x <= baseX + SPRITE + STEP - 1; x++) begin
                    bit found = 1'b0;
                    bit vis = 1'b1;
                    for (int k = 0; k < wallX.size(); k++) begin
                        if (wallX[k] == x && wallY[k] == y) begin
                            found = 1'b1;
                            vis = wallVis[k];
                        end
                    end
                    applyStimulus(x, y, vis, found, bScan);
                end
            end
        end
        applyStimulus(0, UPD_LINE, 1'b0, 1'b0, bScan);
        applyStimulus(1, UPD_LINE, 1'b0, 1'b0, bUpd);
    endtask

    function automatic int priDir(input logic [3:0] b);
        if (b[3]) return 2;
        if (b[2]) return 3;
        if (b[1]) return 1;
        return 0;
    endfunction

    function automatic bit inStrip(input int d, input int x, input int y, input int wx, input int wy);
        case (d)
            0: return (wy >= y && wy < y + SPRITE) && (wx >= x + SPRITE && wx < x + SPRITE + STEP);
            1: return (wy >= y && wy < y + SPRITE) && (wx >= x - STEP && wx < x);
            2: return (wx >= x && wx < x + SPRITE) && (wy >= y - STEP && wy < y);
            default: return (wx >= x && wx < x + SPRITE) && (wy >= y + SPRITE && wy < y + SPRITE + STEP);
        endcase
    endfunction

    // Frame-level model: what one whole frame should do to position, heading and moving.
    task automatic modelFrame(input logic [3:0] bScan, input logic [3:0] bUpd);
        bit [3:0] blk = 4'b0000;
        int eff, nd, nx, ny;
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < wallX.size(); k++)
                if (wallVis[k] && inStrip(d, mX, mY, wallX[k], wallY[k])) blk[d] = 1'b1;
        mPrimed = 1'b1;
        if (bScan != 0) mReq = priDir(bScan);
        eff = (bUpd != 0) ? priDir(bUpd) : mReq;
        mReq = eff;
        if (mDiv != MOVE_DIV - 1) begin
            mDiv++;
            return;
        end
        mDiv = 0;
        nd = blk[eff] ? mDir : eff;
        mDir = nd;
        if (blk[nd]) begin
            mMov = 1'b0;
            return;
        end
        nx = mX;
        ny = mY;
        case (nd)
`ifdef PAC_TUNNEL_EN
            0: nx = (mX + STEP > X_MAX) ? X_MIN : mX + STEP;
            1: nx = (mX - STEP < X_MIN) ? X_MAX : mX - STEP;
`else
            0: nx = (mX + STEP > X_MAX) ? X_MAX : mX + STEP;
            1: nx = (mX - STEP < X_MIN) ? X_MIN : mX - STEP;
`endif
            2: ny = (mY - STEP < Y_MIN) ? Y_MIN : mY - STEP;
            default: ny = (mY + STEP > Y_MAX) ? Y_MAX : mY + STEP;
        endcase
        mMov = (nx != mX) || (ny != mY);
        mX = nx;
        mY = ny;
    endtask

    initial begin
        int prevX, prevY;

        tbl[0]  = '{4'h0, 4'h0, 0, 314, 254, 1, 0};
        tbl[1]  = '{4'h0, 4'h0, 0, 312, 254, 1, 1};
        tbl[2]  = '{4'h0, 4'h0, 0, 312, 254, 1, 1};
        tbl[3]  = '{4'h2, 4'h2, 1, 312, 254, 1, 0};
        tbl[4]  = '{4'h0, 4'h0, 0, 312, 254, 1, 0};
        tbl[5]  = '{4'h8, 4'h8, 2, 310, 254, 1, 1};
        tbl[6]  = '{4'h8, 4'h8, 0, 310, 254, 1, 1};
        tbl[7]  = '{4'h8, 4'h8, 0, 310, 252, 2, 1};
        tbl[8]  = '{4'h0, 4'h0, 0, 310, 252, 2, 1};
        tbl[9]  = '{4'h4, 4'h4, 3, 310, 250, 2, 1};
        tbl[10] = '{4'h1, 4'h0, 0, 310, 250, 2, 1};
        tbl[11] = '{4'h0, 4'h0, 0, 312, 250, 0, 1};
        tbl[12] = '{4'h0, 4'h2, 0, 312, 250, 0, 1};
        tbl[13] = '{4'h0, 4'h0, 1, 314, 250, 0, 1};
        tbl[14] = '{4'h0, 4'h4, 0, 314, 250, 0, 1};
        tbl[15] = '{4'h0, 4'h0, 0, 314, 252, 3, 1};
        tbl[16] = '{4'h0, 4'h0, 0, 314, 252, 3, 1};
        tbl[17] = '{4'h2, 4'h2, 4, 312, 252, 1, 1};

        reset = 1'b1; start = 1'b0; ack = 1'b0;
        repeat (3) applyStimulus(5, 5, 1'b0, 1'b0, 4'h0);
        reset = 1'b0;
        checkOutput("reset", START_X, START_Y, 1, 0);

        for (int f = 0; f < 3; f++) begin
            runFrame(4'h0, 4'h0, 1'b0, START_X, START_Y);
            checkOutput($sformatf("idle_frame%0d", f), START_X, START_Y, 1, 0);
        end

        // Start mid-frame: the first update line has no primed probes and must do nothing.
        start = 1'b1;
        applyStimulus(5, 300, 1'b1, 1'b0, 4'h0);
        start = 1'b0;
        applyStimulus(0, UPD_LINE, 1'b0, 1'b0, 4'h0);
        applyStimulus(1, UPD_LINE, 1'b0, 1'b0, 4'h0);
        checkOutput("unprimed_update", START_X, START_Y, 1, 0);

        prevX = START_X;
        prevY = START_Y;
        for (int i = 0; i < 18; i++) begin
            wallX.delete(); wallY.delete(); wallVis.delete();
            case (tbl[i].wallCode)
                1: begin wallX.push_back(prevX - 1); wallY.push_back(prevY + 5); wallVis.push_back(1'b1); end
                2: begin wallX.push_back(prevX + 3); wallY.push_back(prevY - 1); wallVis.push_back(1'b1); end
                3: begin wallX.push_back(prevX + 3); wallY.push_back(prevY + SPRITE + 1); wallVis.push_back(1'b1); end
                4: begin wallX.push_back(prevX - 1); wallY.push_back(prevY + 5); wallVis.push_back(1'b0); end
                default: ;
            endcase
            runFrame(tbl[i].bScan, tbl[i].bUpd, 1'b1, prevX, prevY);
            checkOutput($sformatf("table%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ed, tbl[i].em);
            prevX = tbl[i].ex;
            prevY = tbl[i].ey;
        end

        // Walk left to the X_MIN edge (87 moves over 174 frames), then push past it.
        wallX.delete(); wallY.delete(); wallVis.delete();
        repeat (174) runFrame(4'h2, 4'h2, 1'b0, 0, 0);
        checkOutput("reach_xmin", X_MIN, 252, 1, 1);
        repeat (2) runFrame(4'h2, 4'h2, 1'b0, 0, 0);
`ifdef PAC_TUNNEL_EN
        checkOutput("past_xmin", X_MAX, 252, 1, 1);
`else
        checkOutput("past_xmin", X_MIN, 252, 1, 0);
`endif

        // ack and start together: ack wins, block returns to idle with start values.
        ack = 1'b1; start = 1'b1;
        applyStimulus(5, 5, 1'b0, 1'b0, 4'h0);
        ack = 1'b0; start = 1'b0;
        checkOutput("ack_start", START_X, START_Y, 1, 0);
        repeat (2) runFrame(4'h2, 4'h2, 1'b0, 0, 0);
        checkOutput("ack_idle", START_X, START_Y, 1, 0);

        // Randomized play against the frame model.
        ack = 1'b1;
        applyStimulus(5, 5, 1'b0, 1'b0, 4'h0);
        ack = 1'b0;
        start = 1'b1;
        applyStimulus(5, 100, 1'b0, 1'b0, 4'h0);
        start = 1'b0;
        mX = START_X; mY = START_Y; mDir = 1; mReq = 1; mDiv = 0; mMov = 1'b0; mPrimed = 1'b0;
        for (int f = 0; f < 60; f++) begin
            logic [3:0] bScan, bUpd;
            int nw;
            bScan = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            bUpd  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : bScan;
            wallX.delete(); wallY.delete(); wallVis.delete();
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) begin
                wallX.push_back(mX - STEP + int'($urandom_range(0, SPRITE + 2 * STEP - 1)));
                wallY.push_back(mY - STEP + int'($urandom_range(0, SPRITE + 2 * STEP - 1)));
                wallVis.push_back($urandom_range(0, 4) != 0);
            end
            runFrame(bScan, bUpd, 1'b1, mX, mY);
            modelFrame(bScan, bUpd);
            checkOutput($sformatf("rand%0d", f), mX, mY, mDir, int'(mMov));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
